// File: rtl/mem_access_pkg.sv
// Shared types and defaults for the data-memory bus interface.
package mem_access_pkg;
  localparam int DATA_W_DEF  = 16;
  localparam int ADDR_W_DEF  = 16;
  localparam int TIMEOUT_DEF = 255;
  localparam int CNT_W_DEF   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/mem_timeout_counter.sv
// Wait-cycle counter for bus accesses; hit flags the last permitted cycle.
module mem_timeout_counter
  import mem_access_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clock,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic hit
);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // cnt is 0 on the first waiting cycle, so TIMEOUT-1 marks the TIMEOUT-th cycle.
  assign hit = enable && (cnt == CNT_W'(TIMEOUT - 1));
endmodule

// File: rtl/mem_access_unit.sv
// Data-memory bus interface: one load/store at a time, valid/ready request, stall while busy.
// Optional abort of stuck accesses when MEM_TIMEOUT_EN is defined.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic              mem_stall,
  output logic              bus_valid,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ready,
  input  logic              bus_rvalid,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              err,
  output state_t            state
);
  // Handshake: a request is transferred on a cycle where bus_valid && bus_ready;
  // bus_valid, bus_we, bus_addr and bus_wdata stay constant from assertion until that cycle.
  logic timeout_hit;
  logic done_q;
  logic err_q;

  if (2 ** CNT_W <= TIMEOUT) begin : g_cnt_w_check
    $error("CNT_W too narrow for TIMEOUT");
  end

`ifdef MEM_TIMEOUT_EN
  mem_timeout_counter #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clock  (clock),
    .rst    (rst),
    .clear  ((state == IDLE) && mem_req),
    .enable ((state == ADDR) || (state == RESP)),
    .hit    (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      bus_valid <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      mem_rdata <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_req) begin
            bus_we    <= mem_we;
            bus_addr  <= mem_addr;
            bus_wdata <= mem_wdata;
            bus_valid <= 1'b1;
            state     <= ADDR;
          end
        end
        ADDR: begin
          // A completed handshake takes priority over an abort on the same cycle.
          if (bus_ready) begin
            bus_valid <= 1'b0;
            if (bus_we) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else if (bus_rvalid) begin
              mem_rdata <= bus_rdata;
              state     <= DONE;
              done_q    <= 1'b1;
            end else begin
              state <= RESP;
            end
          end else if (timeout_hit) begin
            bus_valid <= 1'b0;
            state     <= DONE;
            done_q    <= 1'b1;
            err_q     <= 1'b1;
          end
        end
        RESP: begin
          if (bus_rvalid) begin
            mem_rdata <= bus_rdata;
            state     <= DONE;
            done_q    <= 1'b1;
          end else if (timeout_hit) begin
            state  <= DONE;
            done_q <= 1'b1;
            err_q  <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_done  = done_q;
  assign err       = err_q;
  assign mem_stall = rst && (((state == IDLE) && mem_req) || (state == ADDR) || (state == RESP));
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit; expectations are hand-computed per vector.
module tb_mem_access_unit;
  import mem_access_pkg::*;

  logic        clock = 1'b0;
  logic        rst;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_done;
  logic        mem_stall;
  logic        bus_valid;
  logic        bus_we;
  logic [15:0] bus_addr;
  logic [15:0] bus_wdata;
  logic        bus_ready;
  logic        bus_rvalid;
  logic [15:0] bus_rdata;
  logic        err;
  state_t      state;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mem_access_unit #(
    .DATA_W  (16),
    .ADDR_W  (16),
    .TIMEOUT (4),
    .CNT_W   (8)
  ) dut (
    .clock      (clock),
    .rst        (rst),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_done   (mem_done),
    .mem_stall  (mem_stall),
    .bus_valid  (bus_valid),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_ready  (bus_ready),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata),
    .err        (err),
    .state      (state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Compact check of the control outputs: valid, stall, done, err.
  task automatic check_ctl(input string tag, input logic v, input logic s, input logic d, input logic e);
    check({tag, ".bus_valid"}, {31'd0, bus_valid}, {31'd0, v});
    check({tag, ".mem_stall"}, {31'd0, mem_stall}, {31'd0, s});
    check({tag, ".mem_done"},  {31'd0, mem_done},  {31'd0, d});
    check({tag, ".err"},       {31'd0, err},       {31'd0, e});
  endtask

  task automatic request(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
    mem_req   = 1'b1;
    mem_we    = we;
    mem_addr  = addr;
    mem_wdata = wdata;
  endtask

  initial begin
    rst        = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    bus_ready  = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata  = '0;

    // 1. reset held with request and ready asserted
    request(1'b1, 16'h0001, 16'h0101);
    bus_ready = 1'b1;
    #1;
    check_ctl("rst0", 0, 0, 0, 0);
    repeat (3) step();
    check_ctl("rst3", 0, 0, 0, 0);
    check("rst.rdata", {16'd0, mem_rdata}, 32'h0);
    check("rst.addr", {16'd0, bus_addr}, 32'h0);
    rst = 1'b1;
    #1;
    check_ctl("rel.idle", 0, 1, 0, 0);
    step();
    mem_req = 1'b0;
    check_ctl("rel.addr", 1, 1, 0, 0);
    check("rel.bus_addr", {16'd0, bus_addr}, 32'h0001);
    step();
    check_ctl("rel.done", 0, 0, 1, 0);
    step();
    check_ctl("rel.idle2", 0, 0, 0, 0);

    // 2. zero-wait store
    request(1'b1, 16'h0010, 16'hBEEF);
    bus_ready = 1'b1;
    #1;
    check_ctl("st.c0", 0, 1, 0, 0);
    step();
    mem_req = 1'b0;
    check_ctl("st.c1", 1, 1, 0, 0);
    check("st.bus_addr", {16'd0, bus_addr}, 32'h0010);
    check("st.bus_wdata", {16'd0, bus_wdata}, 32'hBEEF);
    check("st.bus_we", {31'd0, bus_we}, 32'h1);
    step();
    check_ctl("st.c2", 0, 0, 1, 0);
    check("st.rdata", {16'd0, mem_rdata}, 32'h0);
    step();
    check_ctl("st.c3", 0, 0, 0, 0);

    // 3. slow load: ready after 2 ADDR cycles, response on 3rd RESP cycle
    bus_ready = 1'b0;
    request(1'b0, 16'h0020, 16'h0000);
    step();
    mem_req = 1'b0;
    check_ctl("ld.a1", 1, 1, 0, 0);
    check("ld.bus_we", {31'd0, bus_we}, 32'h0);
    step();
    check_ctl("ld.a2", 1, 1, 0, 0);
    check("ld.bus_addr", {16'd0, bus_addr}, 32'h0020);
    bus_ready = 1'b1;
    step();
    bus_ready = 1'b0;
    check_ctl("ld.r1", 0, 1, 0, 0);
    step();
    check_ctl("ld.r2", 0, 1, 0, 0);
    step();
    check_ctl("ld.r3", 0, 1, 0, 0);
    bus_rvalid = 1'b1;
    bus_rdata  = 16'h1234;
    step();
    bus_rvalid = 1'b0;
    check_ctl("ld.done", 0, 0, 1, 0);
    check("ld.rdata", {16'd0, mem_rdata}, 32'h1234);
    step();
    check_ctl("ld.after", 0, 0, 0, 0);

    // 4. back-to-back: same-cycle load response, then store
    request(1'b0, 16'h0030, 16'h0000);
    bus_ready  = 1'b1;
    bus_rvalid = 1'b1;
    bus_rdata  = 16'h00AA;
    step();
    mem_req = 1'b0;
    check_ctl("bb.addr", 1, 1, 0, 0);
    step();
    bus_rdata = 16'h5A5A;
    check_ctl("bb.done", 0, 0, 1, 0);
    check("bb.rdata", {16'd0, mem_rdata}, 32'h00AA);
    step();
    request(1'b1, 16'h0031, 16'h5555);
    #1;
    check_ctl("bb.idle", 0, 1, 0, 0);
    step();
    mem_req = 1'b0;
    check("bb.st_addr", {16'd0, bus_addr}, 32'h0031);
    check("bb.st_we", {31'd0, bus_we}, 32'h1);
    step();
    bus_rvalid = 1'b0;
    check_ctl("bb.st_done", 0, 0, 1, 0);
    check("bb.rdata_kept", {16'd0, mem_rdata}, 32'h00AA);
    step();

    // 5. reset during RESP
    request(1'b0, 16'h0040, 16'h0000);
    bus_ready = 1'b1;
    step();
    mem_req = 1'b0;
    step();
    bus_ready = 1'b0;
    check_ctl("rr.resp", 0, 1, 0, 0);
    rst = 1'b0;
    #1;
    check_ctl("rr.in_rst", 0, 0, 0, 0);
    check("rr.rdata0", {16'd0, mem_rdata}, 32'h0);
    bus_rvalid = 1'b1;
    bus_rdata  = 16'hFFFF;
    step();
    rst = 1'b1;
    step();
    step();
    bus_rvalid = 1'b0;
    check_ctl("rr.after", 0, 0, 0, 0);
    check("rr.rdata", {16'd0, mem_rdata}, 32'h0);

    // 6. bus never ready
    request(1'b0, 16'h0050, 16'h0000);
    bus_ready = 1'b0;
    step();
    mem_req = 1'b0;
`ifdef MEM_TIMEOUT_EN
    repeat (3) step();
    check_ctl("to.a3", 1, 1, 0, 0);
    step();
    check_ctl("to.abort", 0, 0, 1, 1);
    check("to.rdata", {16'd0, mem_rdata}, 32'h0);
    step();
    check_ctl("to.idle", 0, 0, 0, 0);
`else
    repeat (20) step();
    check_ctl("nt.stuck", 1, 1, 0, 0);
    bus_ready = 1'b1;
    bus_rvalid = 1'b1;
    bus_rdata = 16'h7777;
    step();
    bus_ready = 1'b0;
    bus_rvalid = 1'b0;
    check_ctl("nt.done", 0, 0, 1, 0);
    check("nt.rdata", {16'd0, mem_rdata}, 32'h7777);
    step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Data-memory bus interface that sits directly downstream of the memory stage of the 16-bit pipelined core.
- Takes one load or store request at a time from the memory stage.
- Drives it onto the external data bus with a valid/ready handshake and collects the read response.
- Returns load data to the memory stage and raises a pipeline stall while the access is outstanding.

Parameters:
DATA_W, 16, data bus width in bits
ADDR_W, 16, word address width in bits
TIMEOUT, 255, cycles an access may wait before it is aborted (used only with MEM_TIMEOUT_EN)
CNT_W, 8, timeout counter width; must satisfy 2^CNT_W > TIMEOUT

Ports:
clock  in  1  single clock, rising edge
rst  in  1  reset, asynchronous, active-low
mem_req  in  1  memory stage requests an access (memread or memwrite)
mem_we  in  1  1 = store, 0 = load
mem_addr  in  ADDR_W  word address (ALU result)
mem_wdata  in  DATA_W  store data (B operand)
mem_rdata  out  DATA_W  last completed load data
mem_done  out  1  one-cycle pulse: access complete
mem_stall  out  1  hold the pipeline
bus_valid  out  1  bus request valid
bus_we  out  1  bus write enable
bus_addr  out  ADDR_W  bus address
bus_wdata  out  DATA_W  bus write data (drives core write_out)
bus_ready  in  1  bus accepts the request
bus_rvalid  in  1  read response valid
bus_rdata  in  DATA_W  read data (from core read_in)
err  out  1  one-cycle pulse: access aborted

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All outputs and registers go to 0, including mem_rdata; bus_valid drops immediately.
- Request capture: in IDLE with mem_req=1, latch mem_we/mem_addr/mem_wdata at the clock edge and go to ADDR.
- States and transitions: IDLE -> ADDR -> (RESP) -> DONE -> IDLE.
  - ADDR: bus_valid=1; bus_we/bus_addr/bus_wdata come from the latched registers.
    - On bus_ready=1, a store goes to DONE.
    - On bus_ready=1, a load goes to RESP.
    - If bus_ready=1 and bus_rvalid=1 in the same cycle, a load captures bus_rdata and goes directly to DONE.
  - RESP: on bus_rvalid=1, capture bus_rdata into mem_rdata and go to DONE.
  - DONE: mem_done=1 for exactly one cycle, mem_stall=0, unconditional return to IDLE. The memory stage advances at this edge.
- mem_stall, combinational: (IDLE and mem_req) or ADDR or RESP. A request therefore stalls from its first cycle.
- Bus rules:
  - bus_valid is never retracted before bus_ready.
  - Address, data and we stay stable while bus_valid=1.
  - bus_valid=0 in IDLE, RESP and DONE.
- mem_rdata holds its value until the next load completes; stores do not change it.
- bus_rvalid outside RESP (or outside the same-cycle ADDR case) is ignored.
- Latency with a zero-wait bus: store done 2 cycles after capture; load done 2 cycles after capture (same-cycle response) or 3 (next-cycle response).
- No alignment or wrap-around checks: addresses are word addresses and pass through unchanged.

Optional Feature:
MEM_TIMEOUT_EN.
- Defined: a counter clears on entry to ADDR and increments each cycle in ADDR or RESP. When it reaches TIMEOUT, go to DONE with err=1 for that same cycle. A load abort leaves mem_rdata unchanged.
- Not defined: no counter is built, the unit waits indefinitely, and err is tied to 0.

Decomposition:
- Package mem_access_pkg: state enum (IDLE, ADDR, RESP, DONE), DATA_W/ADDR_W defaults, TIMEOUT default.
- One sub-module, mem_timeout_counter (clear, enable, hit), instantiated only under MEM_TIMEOUT_EN.

Test Plan:
1. Reset: hold rst=0 with mem_req=1 and bus_ready=1 -> all outputs stay 0; after release, the first capture happens on the next edge.
2. Zero-wait store: mem_req=1, mem_we=1, addr 0x0010, wdata 0xBEEF, bus_ready=1 -> bus_valid with 0x0010/0xBEEF on cycle 1; mem_done pulse on cycle 2; mem_stall high on cycles 0–1; mem_rdata unchanged.
3. Slow load: addr 0x0020, bus_ready asserted after 2 cycles in ADDR, bus_rvalid with 0x1234 after 3 cycles in RESP -> bus_valid held for the whole ADDR phase; mem_rdata=0x1234 on the DONE cycle; exactly one mem_done pulse.
4. Back-to-back: load 0x0030 (response 0x00AA), then a store to 0x0031 on the cycle after DONE -> second request is captured from IDLE; mem_rdata stays 0x00AA through the store.
5. Reset during RESP: rst=0 mid-load -> bus_valid=0 and mem_stall=0 immediately; a later bus_rvalid with 0xFFFF is ignored and mem_rdata stays 0.
6. With MEM_TIMEOUT_EN and TIMEOUT=4: bus_ready never asserts -> err and mem_done pulse together on the 4th cycle after entering ADDR, then IDLE; without the macro, the unit stays stalled.
